// File: rtl/count_seq.sv
// count_seq: sequences one to four back-to-back runs of a downstream down-counter.
// Each run issues a start pulse, waits for the counter to arm (go non-zero) and
// then waits for it to drain back to zero. Both waits are bounded, and an expired
// bound raises a sticky timeout flag. All outputs come straight from flops.
module count_seq #(
    parameter int ARM_TO = 4,   // max ARM cycles for cnt_down to leave zero
    parameter int RUN_TO = 20   // max WAIT cycles for cnt_down to return to zero
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       req_valid,
    input  logic [1:0] req_runs,
    output logic       req_ready,
    input  logic [3:0] cnt_down,
    output logic       count_down_start,
    output logic       busy,
    output logic       done_pulse,
    output logic [7:0] runs_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam int MAX_TO = (ARM_TO > RUN_TO) ? ARM_TO : RUN_TO;
    localparam int CW     = $clog2(MAX_TO + 1);

    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_TO - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_TO - 1);

    state_t        state;
    logic [1:0]    remaining;   // runs still to go after the current one
    logic [CW-1:0] cyc;         // cycles spent in the current ARM or WAIT visit

    // Single-process FSM: state, counters and every output register update together.
    always_ff @(posedge clk) begin
        // NOTE: all state here is plain flops (no memories), so every register
        // gets an explicit reset value; non-blocking assignments keep the update
        // order-independent within the block.
        if (!areset_n) begin
            state            <= S_IDLE;
            remaining        <= 2'd0;
            cyc              <= '0;
            req_ready        <= 1'b1;
            count_down_start <= 1'b0;
            busy             <= 1'b0;
            done_pulse       <= 1'b0;
            runs_done        <= 8'd0;
            timeout_err      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the transitions
            // that enter START or DONE raise them, so they last one cycle.
            count_down_start <= 1'b0;
            done_pulse       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        remaining        <= req_runs;
                        timeout_err      <= 1'b0;
                        state            <= S_START;
                        count_down_start <= 1'b1;
                        busy             <= 1'b1;
                        req_ready        <= 1'b0;
                    end
                end

                S_START: begin
                    state <= S_ARM;
                    cyc   <= '0;
                end

                S_ARM: begin
                    if (cnt_down != 4'd0) begin
                        state <= S_WAIT;
                        cyc   <= '0;
                    end else if (cyc == ARM_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                        cyc         <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end

                S_WAIT: begin
                    // Completion is tested first so a drain seen on the last
                    // allowed cycle still counts as a finished run.
                    if (cnt_down == 4'd0) begin
                        if (runs_done != 8'hFF) begin
                            runs_done <= runs_done + 8'd1;
                        end
                        cyc <= '0;
                        if (remaining != 2'd0) begin
                            remaining <= remaining - 2'd1;
                            state     <= S_GAP;
                        end else begin
                            state      <= S_DONE;
                            done_pulse <= 1'b1;
                        end
                    end else if (cyc == RUN_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                        cyc         <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end

                S_GAP: begin
                    state            <= S_START;
                    count_down_start <= 1'b1;
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq.sv
// tb_count_seq: randomized bench for count_seq. A downstream counter emulator
// answers start pulses, a request-level model predicts each request's outcome
// (start count, busy length, done/timeout, runs_done), and a monitor compares
// the observed outcome whenever busy falls.
module tb_count_seq;

    localparam int ARM_TO = 4;
    localparam int RUN_TO = 20;

    logic       clk       = 1'b0;
    logic       areset_n  = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_runs  = 2'd0;
    logic [3:0] cnt_down  = 4'd0;
    logic       req_ready;
    logic       count_down_start;
    logic       busy;
    logic       done_pulse;
    logic [7:0] runs_done;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    typedef enum {K_DONE, K_TIMEOUT, K_ABORT} kind_e;
    typedef struct {
        kind_e kind;
        int    starts;
        int    busy_cycles;
        int    dones;
        int    runs_done;
        bit    timeout;
    } exp_t;

    exp_t sb[$];

    // Counter emulator configuration for the current request:
    // cfg_d  = extra cycles before the counter loads,
    // cfg_ld = loaded value, cfg_h = cycles it holds before counting down.
    int cfg_d  = 0;
    int cfg_ld = 1;
    int cfg_h  = 0;
    int model_rd = 0;

    always #5 clk = ~clk;

    count_seq #(.ARM_TO(ARM_TO), .RUN_TO(RUN_TO)) dut (
        .clk              (clk),
        .areset_n         (areset_n),
        .req_valid        (req_valid),
        .req_runs         (req_runs),
        .req_ready        (req_ready),
        .cnt_down         (cnt_down),
        .count_down_start (count_down_start),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .runs_done        (runs_done),
        .timeout_err      (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Request-level model: walks the runs using the timing rules
    // START=1, ARM=d+2 (or ARM_TO on timeout), WAIT=ld+h (or RUN_TO), GAP=1, DONE=1.
    function automatic exp_t model(input int r, input int d, input int ld, input int h);
        exp_t e;
        e.kind        = K_DONE;
        e.starts      = 0;
        e.busy_cycles = 0;
        e.dones       = 0;
        e.timeout     = 1'b0;
        for (int k = 0; k <= r; k++) begin
            e.starts++;
            e.busy_cycles++;
            if (d + 2 > ARM_TO) begin
                e.busy_cycles += ARM_TO;
                e.kind = K_TIMEOUT;
                break;
            end
            e.busy_cycles += d + 2;
            if (ld + h > RUN_TO) begin
                e.busy_cycles += RUN_TO;
                e.kind = K_TIMEOUT;
                break;
            end
            e.busy_cycles += ld + h;
            if (model_rd < 255) model_rd++;
            if (k < r) e.busy_cycles++;
        end
        if (e.kind == K_DONE) begin
            e.busy_cycles++;
            e.dones = 1;
        end else begin
            e.timeout = 1'b1;
        end
        e.runs_done = model_rd;
        return e;
    endfunction

    // Downstream counter emulator.
    initial begin
        int phase;
        int wait_left;
        int hold_left;
        bit s;
        phase = 0;
        wait_left = 0;
        hold_left = 0;
        forever begin
            @(negedge clk);
            s = count_down_start;
            @(posedge clk);
            #1;
            if (!areset_n) begin
                phase    = 0;
                cnt_down = 4'd0;
            end else if (s) begin
                phase     = 1;
                wait_left = cfg_d;
                hold_left = cfg_h;
                cnt_down  = 4'd0;
            end else if (phase == 1) begin
                if (wait_left == 0) begin
                    cnt_down = 4'(cfg_ld);
                    phase    = 2;
                end else begin
                    wait_left--;
                end
            end else if (phase == 2) begin
                if (hold_left > 0) hold_left--;
                else if (cnt_down != 4'd0) cnt_down = cnt_down - 4'd1;
            end
        end
    end

    // Monitor: accumulates per-request observations and scores them when busy falls.
    initial begin
        bit   prev_busy;
        int   starts;
        int   busy_n;
        int   dones;
        exp_t e;
        prev_busy = 1'b0;
        starts = 0;
        busy_n = 0;
        dones  = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (count_down_start === 1'b1) starts++;
            if (done_pulse === 1'b1) dones++;
            check("ready_is_not_busy", req_ready, {31'd0, ~busy});
            if (prev_busy && busy !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_end_of_busy", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("starts", starts, e.starts);
                    check("done_pulses", dones, e.dones);
                    check("runs_done", runs_done, e.runs_done);
                    check("timeout_err", timeout_err, {31'd0, e.timeout});
                    if (e.kind != K_ABORT) check("busy_cycles", busy_n, e.busy_cycles);
                end
                starts = 0;
                busy_n = 0;
                dones  = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // Waits for IDLE, issues one request, then pokes req_valid while the DUT is busy.
    task automatic issue(input int r, input int d, input int ld, input int h, input bit abort);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready !== 1'b1 && n < 200);
        check("ready_wait", req_ready, 1);
        if (req_ready !== 1'b1) return;
        #1;
        cfg_d     = d;
        cfg_ld    = ld;
        cfg_h     = h;
        req_runs  = 2'(r);
        req_valid = 1'b1;
        if (abort) begin
            e.kind        = K_ABORT;
            e.starts      = 1;
            e.busy_cycles = 0;
            e.dones       = 0;
            e.timeout     = 1'b0;
            model_rd      = 0;
            e.runs_done   = 0;
        end else begin
            e = model(r, d, ld, h);
        end
        sb.push_back(e);
        @(negedge clk);
        check("start_on_accept", count_down_start, 1);
        check("accept_clears_timeout", timeout_err, 0);
        // Every request stays busy at least five cycles, so these pokes land in START/ARM.
        for (int i = 0; i < 3; i++) begin
            #1;
            req_valid = 1'($urandom_range(0, 1));
            req_runs  = 2'($urandom);
            @(negedge clk);
        end
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int ld;
        int h;
        int pick;

        areset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", count_down_start, 0);
        check("rst_done", done_pulse, 0);
        check("rst_runs_done", runs_done, 0);
        check("rst_timeout", timeout_err, 0);
        #1 areset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        issue(0, 0, 15, 0, 0);    // single run, 15..0, 19 busy cycles
        issue(2, 1, 6, 2, 0);     // three runs separated by GAP
        issue(0, 15, 5, 0, 0);    // arm timeout
        issue(0, 0, 5, 255, 0);   // run timeout, counter stuck at 5
        issue(0, 0, 3, 0, 0);     // next accept clears timeout_err
        issue(0, 0, 1, 19, 0);    // drain on the last allowed WAIT cycle
        issue(0, 0, 1, 20, 0);    // drain one cycle too late
        issue(1, 2, 15, 5, 0);    // latest possible arm, WAIT exactly RUN_TO
        issue(3, 3, 4, 0, 0);     // arm one cycle too late

        for (int i = 0; i < 40; i++) begin
            ld   = $urandom_range(1, 15);
            pick = $urandom_range(0, 7);
            if (pick == 0)      h = RUN_TO - ld;
            else if (pick == 1) h = RUN_TO - ld + 1;
            else                h = $urandom_range(0, 6);
            issue($urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2), ld, h, 0);
        end

        // Reset while in WAIT.
        issue(0, 0, 5, 255, 1);
        @(negedge clk);
        @(negedge clk);
        #1 areset_n = 1'b0;
        @(negedge clk);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_start", count_down_start, 0);
        check("midrun_rst_done", done_pulse, 0);
        check("midrun_rst_runs_done", runs_done, 0);
        check("midrun_rst_timeout", timeout_err, 0);
        #1 areset_n = 1'b1;
        @(negedge clk);
        check("midrun_release_ready", req_ready, 1);
        check("midrun_release_start", count_down_start, 0);
        check("midrun_release_done", done_pulse, 0);

        // Saturation: 256 guaranteed-good single runs from runs_done=0.
        for (int i = 0; i < 256; i++) begin
            issue(0, $urandom_range(0, 2), $urandom_range(1, 3), 0, 0);
        end

        n = 0;
        while ((sb.size() != 0 || busy === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("runs_done_saturated", runs_done, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
